// File: rtl/d_mem_dma_pkg.sv
// rtl/d_mem_dma_pkg.sv - shared encodings and widths for the data-memory DMA engine
package d_mem_dma_pkg;

   localparam int MEM_AW = 8;
   localparam int MEM_DW = 16;

   typedef enum logic [1:0] {
      OP_FILL = 2'b00,
      OP_COPY = 2'b01,
      OP_SUM  = 2'b10,
      OP_RSVD = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_COPY_RD,
      S_COPY_WR,
      S_SUM,
      S_FIN
   } state_t;

endpackage

// File: rtl/d_mem_dma.sv
// rtl/d_mem_dma.sv - block fill/copy/checksum engine that owns the data-memory port while busy
module d_mem_dma
   import d_mem_dma_pkg::*;
#(
   parameter int AW = MEM_AW,
   parameter int DW = MEM_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [1:0]    op,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [AW:0]   len,
   input  logic [DW-1:0] fill_data,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [DW-1:0] result,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [AW:0] ONE = (AW+1)'(1);

   state_t        state, ns;
   op_t           op_q, c_op;
   logic [AW-1:0] src_q, dst_q, c_src, c_dst;
   logic [AW:0]   len_q, c_len, idx, nidx;
   logic [DW-1:0] fill_q, c_fill, hold, hold_n, acc, acc_n;
   logic          last;

   logic          busy_n, done_n, err_n, we_n;
   logic [AW-1:0] addr_n;
   logic [DW-1:0] wdata_n, result_n;

   // While IDLE the command is still on the inputs; afterwards only the latched copy counts.
   always_comb begin
      if (state == S_IDLE) begin
         c_op   = op_t'(op);
         c_src  = src_addr;
         c_dst  = dst_addr;
         c_len  = len;
         c_fill = fill_data;
      end else begin
         c_op   = op_q;
         c_src  = src_q;
         c_dst  = dst_q;
         c_len  = len_q;
         c_fill = fill_q;
      end
   end

   assign last = (idx + ONE) == c_len;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         op_q      <= OP_FILL;
         src_q     <= '0;
         dst_q     <= '0;
         len_q     <= '0;
         fill_q    <= '0;
         idx       <= '0;
         hold      <= '0;
         acc       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         result    <= '0;
      end else begin
         state <= ns;
         idx   <= nidx;
         hold  <= hold_n;
         acc   <= acc_n;
         if (state == S_IDLE && start) begin
            op_q   <= c_op;
            src_q  <= c_src;
            dst_q  <= c_dst;
            len_q  <= c_len;
            fill_q <= c_fill;
         end
         busy      <= busy_n;
         done      <= done_n;
         err       <= err_n;
         mem_we    <= we_n;
         mem_addr  <= addr_n;
         mem_wdata <= wdata_n;
         result    <= result_n;
      end
   end

   always_comb begin
      ns     = state;
      nidx   = idx;
      hold_n = hold;
      acc_n  = acc;
      case (state)
         S_IDLE: begin
            if (start) begin
               nidx  = '0;
               acc_n = '0;
               if (c_len == '0 || c_op == OP_RSVD) ns = S_FIN;
               else if (c_op == OP_FILL)           ns = S_FILL;
               else if (c_op == OP_COPY)           ns = S_COPY_RD;
               else                                ns = S_SUM;
            end
         end
         S_FILL: begin
            if (last) ns = S_FIN;
            else      nidx = idx + ONE;
         end
         S_COPY_RD: begin
            ns     = S_COPY_WR;
            hold_n = mem_rdata;
         end
         S_COPY_WR: begin
            if (last) ns = S_FIN;
            else begin
               ns   = S_COPY_RD;
               nidx = idx + ONE;
            end
         end
         S_SUM: begin
            acc_n = acc + mem_rdata;
            if (last) ns = S_FIN;
            else      nidx = idx + ONE;
         end
         default: ns = S_IDLE;
      endcase
   end

   // Outputs are computed for the state being entered so they can be registered.
   always_comb begin
      busy_n   = 1'b0;
      done_n   = 1'b0;
      err_n    = 1'b0;
      we_n     = 1'b0;
      addr_n   = '0;
      wdata_n  = '0;
      result_n = result;
      case (ns)
         S_FILL: begin
            busy_n  = 1'b1;
            we_n    = 1'b1;
            addr_n  = c_dst + nidx[AW-1:0];
            wdata_n = c_fill;
         end
         S_COPY_RD: begin
            busy_n = 1'b1;
            addr_n = c_src + nidx[AW-1:0];
         end
         S_COPY_WR: begin
            busy_n  = 1'b1;
            we_n    = 1'b1;
            addr_n  = c_dst + nidx[AW-1:0];
            wdata_n = hold_n;
         end
         S_SUM: begin
            busy_n = 1'b1;
            addr_n = c_src + nidx[AW-1:0];
         end
         S_FIN: begin
            done_n = 1'b1;
            err_n  = (state == S_IDLE) && (c_op == OP_RSVD);
            if (state == S_SUM) result_n = acc_n;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_d_mem_dma.sv
// tb/tb_d_mem_dma.sv - directed bench with a transaction-level model of d_mem_dma
module tb_d_mem_dma;

   logic        clk, rst, start;
   logic [1:0]  op;
   logic [7:0]  src_addr, dst_addr;
   logic [8:0]  len;
   logic [15:0] fill_data;
   logic        busy, done, err, mem_we;
   logic [15:0] result, mem_wdata, mem_rdata;
   logic [7:0]  mem_addr;

   logic [15:0] ram [256];
   logic        bd_we;
   logic [7:0]  bd_addr;
   logic [15:0] bd_data;

   typedef struct {
      logic [7:0]  addr;
      logic        we;
      logic [15:0] wdata;
      logic        busy;
      logic        done;
      logic        err;
      logic [15:0] res;
   } exp_t;

   exp_t        q[$];
   exp_t        cur;
   logic [15:0] mref [256];
   logic [15:0] model_res;
   int          tests, fails;
   bit          chk_en;

   d_mem_dma dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_data(fill_data),
      .busy(busy), .done(done), .err(err), .result(result),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Data memory responder: combinational read, write on the clock edge.
   assign mem_rdata = ram[mem_addr];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (bd_we)  ram[bd_addr]  <= bd_data;
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (q.size() != 0) begin
            cur = q.pop_front();
            chk("busy", 32'(busy), 32'(cur.busy));
            chk("done", 32'(done), 32'(cur.done));
            chk("err", 32'(err), 32'(cur.err));
            chk("mem_we", 32'(mem_we), 32'(cur.we));
            chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
            if (cur.we) begin
               chk("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
               mref[cur.addr] = cur.wdata;
            end
            if (cur.done) model_res = cur.res;
         end else begin
            chk("idle_busy", 32'(busy), 32'h0);
            chk("idle_done", 32'(done), 32'h0);
            chk("idle_err", 32'(err), 32'h0);
            chk("idle_mem_we", 32'(mem_we), 32'h0);
         end
         chk("result", 32'(result), 32'(model_res));
      end
   end

   // Expected per-cycle trace of one command, derived from the operation's meaning.
   task automatic build(input logic [1:0] o, input logic [7:0] s, input logic [7:0] d,
                        input logic [8:0] n, input logic [15:0] f);
      logic [15:0] scr [256];
      logic [15:0] sum, v;
      logic [7:0]  a;
      exp_t        e;
      scr = mref;
      sum = 16'h0;
      if (n != 9'd0 && o != 2'b11) begin
         for (int i = 0; i < int'(n); i++) begin
            if (o == 2'b00) begin
               a = d + 8'(i);
               e = '{addr: a, we: 1'b1, wdata: f, busy: 1'b1, done: 1'b0, err: 1'b0, res: 16'h0};
               q.push_back(e);
               scr[a] = f;
            end else if (o == 2'b01) begin
               a = s + 8'(i);
               v = scr[a];
               e = '{addr: a, we: 1'b0, wdata: 16'h0, busy: 1'b1, done: 1'b0, err: 1'b0, res: 16'h0};
               q.push_back(e);
               a = d + 8'(i);
               e = '{addr: a, we: 1'b1, wdata: v, busy: 1'b1, done: 1'b0, err: 1'b0, res: 16'h0};
               q.push_back(e);
               scr[a] = v;
            end else begin
               a = s + 8'(i);
               sum = sum + scr[a];
               e = '{addr: a, we: 1'b0, wdata: 16'h0, busy: 1'b1, done: 1'b0, err: 1'b0, res: 16'h0};
               q.push_back(e);
            end
         end
      end
      e = '{addr: 8'h00, we: 1'b0, wdata: 16'h0, busy: 1'b0, done: 1'b1, err: (o == 2'b11),
            res: (o == 2'b10 && n != 9'd0) ? sum : model_res};
      q.push_back(e);
   endtask

   task automatic launch(input logic [1:0] o, input logic [7:0] s, input logic [7:0] d,
                         input logic [8:0] n, input logic [15:0] f);
      op = o; src_addr = s; dst_addr = d; len = n; fill_data = f;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      build(o, s, d, n, f);
   endtask

   task automatic run(input logic [1:0] o, input logic [7:0] s, input logic [7:0] d,
                      input logic [8:0] n, input logic [15:0] f, input int exp_done, input int poke);
      int dc;
      dc = -1;
      launch(o, s, d, n, f);
      for (int c = 1; c <= 600; c++) begin
         @(negedge clk);
         if (c == poke) begin
            start = 1'b1; op = 2'b00; dst_addr = 8'h41; len = 9'd1; fill_data = 16'hDEAD;
         end else begin
            start = 1'b0;
         end
         if (done === 1'b1) begin
            dc = c;
            break;
         end
      end
      start = 1'b0;
      chk("done_cycle", 32'(dc), 32'(exp_done));
      @(posedge clk); #1;
   endtask

   task automatic backdoor(input logic [7:0] a, input logic [15:0] dat);
      bd_we = 1'b1; bd_addr = a; bd_data = dat;
      @(posedge clk); #1;
      bd_we = 1'b0;
      mref[a] = dat;
   endtask

   initial begin
      tests = 0; fails = 0; chk_en = 1'b0; model_res = 16'h0;
      rst = 1'b1; start = 1'b0; op = 2'b00; src_addr = 8'h0; dst_addr = 8'h0;
      len = 9'd0; fill_data = 16'h0; bd_we = 1'b0; bd_addr = 8'h0; bd_data = 16'h0;
      for (int i = 0; i < 256; i++) backdoor(8'(i), 16'h1000 + 16'(i));

      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_mem_addr", 32'(mem_addr), 32'h0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
      chk("rst_result", 32'(result), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk_en = 1'b1;
      @(posedge clk); #1;

      run(2'b00, 8'h00, 8'h10, 9'd3, 16'hBEEF, 4, 0);
      chk("fill_10", 32'(ram[8'h10]), 32'hBEEF);
      chk("fill_12", 32'(ram[8'h12]), 32'hBEEF);
      chk("fill_13_untouched", 32'(ram[8'h13]), 32'h1013);

      backdoor(8'h00, 16'h00AB);
      backdoor(8'h01, 16'h3C00);
      run(2'b01, 8'h00, 8'h80, 9'd2, 16'h0, 5, 0);
      chk("copy_80", 32'(ram[8'h80]), 32'h00AB);
      chk("copy_81", 32'(ram[8'h81]), 32'h3C00);

      backdoor(8'hFF, 16'hFFFF);
      backdoor(8'h00, 16'h0002);
      run(2'b10, 8'hFF, 8'h00, 9'd2, 16'h0, 3, 0);
      chk("sum_wrap", 32'(result), 32'h0001);

      run(2'b00, 8'h00, 8'h20, 9'd0, 16'h5555, 1, 0);
      chk("len0_no_write", 32'(ram[8'h20]), 32'h1020);
      run(2'b11, 8'h00, 8'h20, 9'd5, 16'h5555, 1, 0);
      chk("rsvd_no_write", 32'(ram[8'h24]), 32'h1024);
      chk("rsvd_keeps_result", 32'(result), 32'h0001);

      run(2'b00, 8'h00, 8'hFE, 9'd4, 16'h0A0A, 5, 0);
      chk("fill_wrap_01", 32'(ram[8'h01]), 32'h0A0A);
      chk("fill_wrap_02", 32'(ram[8'h02]), 32'h1002);

      run(2'b01, 8'h30, 8'h31, 9'd3, 16'h0, 7, 0);
      chk("overlap_33", 32'(ram[8'h33]), 32'h1030);

      run(2'b01, 8'h20, 8'h40, 9'd4, 16'h0, 9, 3);
      chk("busy_copy_41", 32'(ram[8'h41]), 32'h1021);
      chk("busy_copy_43", 32'(ram[8'h43]), 32'h1023);

      run(2'b10, 8'h00, 8'h00, 9'd256, 16'h0, 257, 0);

      launch(2'b00, 8'h00, 8'h50, 9'd10, 16'h1234);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
      model_res = 16'h0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_mem_we", 32'(mem_we), 32'h0);
      chk("abort_52", 32'(ram[8'h52]), 32'h1234);
      chk("abort_53", 32'(ram[8'h53]), 32'h1053);
      @(posedge clk); #1;
      run(2'b00, 8'h00, 8'h60, 9'd1, 16'h7777, 2, 0);
      chk("after_abort", 32'(ram[8'h60]), 32'h7777);

      @(posedge clk); #1;
      for (int i = 0; i < 256; i++) chk($sformatf("ram_%02h", i), 32'(ram[i]), 32'(mref[i]));
      chk("trace_drained", 32'(q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
